// File: rtl/sample_averager.sv
// -----------------------------------------------------------------------------
// sample_averager
//
// Accumulates 2^k 16-bit samples handed over by the I2C register file, one per
// rising edge of the START control bit, and publishes the truncated mean. It
// also reports a threshold comparison, the number of samples taken so far, and
// BUSY / DONE / DROPPED flags.
//
// Ports
//   clk                 in   system clock (shared with the register interface)
//   rst_n               in   asynchronous active-low reset
//   myRegMCUStatuslsb   in   [0] START, [1] CLEAR, [4:2] AVG_SEL k, [7:5] unused
//   myRegMCUStatusmsb   in   threshold high byte (threshold = {msb, 8'h00})
//   myRegSampleInmsb    in   sample high byte
//   myRegSampleInlsb    in   sample low byte
//   myRegASICStatuslsb  out  [0] BUSY, [1] DONE, [2] ABOVE_THR, [3] DROPPED
//   myRegASICStatusmsb  out  samples accumulated in the current average
//   myRegResultsmsb     out  mean high byte
//   myRegResultslsb     out  mean low byte
// -----------------------------------------------------------------------------
module sample_averager (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] myRegMCUStatuslsb,
    input  logic [7:0] myRegMCUStatusmsb,
    input  logic [7:0] myRegSampleInmsb,
    input  logic [7:0] myRegSampleInlsb,
    output logic [7:0] myRegASICStatuslsb,
    output logic [7:0] myRegASICStatusmsb,
    output logic [7:0] myRegResultsmsb,
    output logic [7:0] myRegResultslsb
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        start_q;
    logic [15:0] sample_q, sample_d;
    logic [22:0] acc_q, acc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  k_lat_q, k_lat_d;
    logic [15:0] result_q, result_d;
    logic        done_q, done_d;
    logic        above_q, above_d;
    logic        dropped_q, dropped_d;

    logic        start_s;
    logic        clear_s;
    logic [2:0]  k_sel_s;
    logic        start_edge_s;
    logic [15:0] thr_s;
    logic [7:0]  target_s;
    logic [22:0] mean_full_s;
    logic        busy_s;
    logic        unused_ctrl_s;

    assign start_s       = myRegMCUStatuslsb[0];
    assign clear_s       = myRegMCUStatuslsb[1];
    assign k_sel_s       = myRegMCUStatuslsb[4:2];
    assign unused_ctrl_s = ^myRegMCUStatuslsb[7:5];
    assign start_edge_s  = start_s & ~start_q;
    assign thr_s         = {myRegMCUStatusmsb, 8'h00};
    // Sample count that completes the sequence, from the k latched at its first sample.
    assign target_s      = 8'd1 << k_lat_q;
    // Full-width shifted sum; upper bits are zero at completion but keep the compare exact.
    assign mean_full_s   = acc_q >> k_lat_q;

    // START history register; tracks the level every cycle, including during CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
        end else begin
            start_q <= start_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; CLEAR forces IDLE and masks any START edge.
    always_comb begin
        state_d = state_q;
        if (clear_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_edge_s) begin
                        state_d = ST_ACCUM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ACCUM: state_d = ST_CHECK;
                ST_CHECK: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM output decode.
    always_comb begin
        busy_s = 1'b0;
        case (state_q)
            ST_IDLE:  busy_s = 1'b0;
            ST_ACCUM: busy_s = 1'b1;
            ST_CHECK: busy_s = 1'b1;
            default:  busy_s = 1'b0;
        endcase
    end

    // Datapath next-state: capture, accumulate, complete, drop detection, clear.
    always_comb begin
        sample_d  = sample_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        k_lat_d   = k_lat_q;
        result_d  = result_q;
        done_d    = done_q;
        above_d   = above_q;
        dropped_d = dropped_q;
        if (clear_s) begin
            acc_d     = 23'd0;
            cnt_d     = 8'd0;
            result_d  = 16'd0;
            done_d    = 1'b0;
            above_d   = 1'b0;
            dropped_d = 1'b0;
        end else begin
            // An edge arriving while a sample is still in flight is lost; flag it sticky.
            if (start_edge_s && (state_q != ST_IDLE)) begin
                dropped_d = 1'b1;
            end else begin
                dropped_d = dropped_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_edge_s) begin
                        sample_d = {myRegSampleInmsb, myRegSampleInlsb};
                        // First sample of a sequence fixes N for the whole sequence.
                        if (cnt_q == 8'd0) begin
                            k_lat_d = k_sel_s;
                            done_d  = 1'b0;
                        end else begin
                            k_lat_d = k_lat_q;
                            done_d  = done_q;
                        end
                    end else begin
                        sample_d = sample_q;
                    end
                end
                ST_ACCUM: begin
                    acc_d = acc_q + {7'd0, sample_q};
                    cnt_d = cnt_q + 8'd1;
                end
                ST_CHECK: begin
                    if (cnt_q == target_s) begin
                        result_d = mean_full_s[15:0];
                        above_d  = (mean_full_s >= {7'd0, thr_s});
                        done_d   = 1'b1;
                        acc_d    = 23'd0;
                        cnt_d    = 8'd0;
                    end else begin
                        result_d = result_q;
                    end
                end
                default: begin
                    acc_d = acc_q;
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q  <= 16'd0;
            acc_q     <= 23'd0;
            cnt_q     <= 8'd0;
            k_lat_q   <= 3'd0;
            result_q  <= 16'd0;
            done_q    <= 1'b0;
            above_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            sample_q  <= sample_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            k_lat_q   <= k_lat_d;
            result_q  <= result_d;
            done_q    <= done_d;
            above_q   <= above_d;
            dropped_q <= dropped_d;
        end
    end

    assign myRegASICStatuslsb = {4'd0, dropped_q, above_q, done_q, busy_s};
    assign myRegASICStatusmsb = cnt_q;
    assign myRegResultsmsb    = result_q[15:8];
    assign myRegResultslsb    = result_q[7:0];

endmodule

// File: tb/tb_sample_averager.sv
// -----------------------------------------------------------------------------
// tb_sample_averager
//
// Drives directed and randomized sample sequences into sample_averager and
// compares its status/result registers with a sum-and-divide reference model.
// -----------------------------------------------------------------------------
module tb_sample_averager;

    logic       clk;
    logic       rst_n;
    logic [7:0] mcu_lsb;
    logic [7:0] thr;
    logic [15:0] smp;
    logic [7:0] asic_lsb;
    logic [7:0] asic_msb;
    logic [7:0] res_msb;
    logic [7:0] res_lsb;

    logic       start_b;
    logic       clear_b;
    logic [2:0] ksel;
    logic [2:0] junk;

    int n_tests;
    int n_fail;

    // Reference model state
    int      m_count;
    longint  m_sum;
    int      m_n;
    int      m_result;
    bit      m_done;
    bit      m_above;
    bit      m_dropped;

    assign mcu_lsb = {junk, ksel, clear_b, start_b};

    sample_averager dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .myRegMCUStatuslsb  (mcu_lsb),
        .myRegMCUStatusmsb  (thr),
        .myRegSampleInmsb   (smp[15:8]),
        .myRegSampleInlsb   (smp[7:0]),
        .myRegASICStatuslsb (asic_lsb),
        .myRegASICStatusmsb (asic_msb),
        .myRegResultsmsb    (res_msb),
        .myRegResultslsb    (res_lsb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_count   = 0;
        m_sum     = 0;
        m_result  = 0;
        m_done    = 0;
        m_above   = 0;
        m_dropped = 0;
    endtask

    // One accepted sample: N is fixed by the first sample of a sequence.
    task automatic model_sample(input logic [15:0] s, input logic [2:0] k, output int mid);
        if (m_count == 0) begin
            m_n    = 1 << k;
            m_done = 0;
        end
        m_sum   += longint'(s);
        m_count += 1;
        mid      = m_count;
        if (m_count == m_n) begin
            m_result = int'(m_sum / m_n);
            m_above  = (m_result >= int'(thr) * 256);
            m_done   = 1;
            m_count  = 0;
            m_sum    = 0;
        end
    endtask

    task automatic check_all(input string tag, input bit exp_busy);
        check_eq({tag, "_busy"},    32'(asic_lsb[0]), 32'(exp_busy));
        check_eq({tag, "_cnt"},     32'(asic_msb), 32'(m_count));
        check_eq({tag, "_result"},  32'({res_msb, res_lsb}), 32'(m_result));
        check_eq({tag, "_done"},    32'(asic_lsb[1]), 32'(m_done));
        check_eq({tag, "_above"},   32'(asic_lsb[2]), 32'(m_above));
        check_eq({tag, "_dropped"}, 32'(asic_lsb[3]), 32'(m_dropped));
        check_eq({tag, "_rsvd"},    32'(asic_lsb[7:4]), 32'd0);
    endtask

    // Present one sample with a START edge and check the cycle-by-cycle response.
    task automatic do_sample(input logic [15:0] s, input logic [2:0] k);
        int mid;
        @(negedge clk);
        smp     = s;
        ksel    = k;
        junk    = 3'($urandom);
        start_b = 1'b1;
        model_sample(s, k, mid);
        @(negedge clk);
        check_eq("busy_t0", 32'(asic_lsb[0]), 32'd1);
        @(negedge clk);
        check_eq("busy_t1", 32'(asic_lsb[0]), 32'd1);
        check_eq("cnt_t1", 32'(asic_msb), 32'(mid));
        @(negedge clk);
        check_all("after", 1'b0);
        start_b = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_b = 1'b1;
        @(negedge clk);
        clear_b = 1'b0;
        model_clear();
        check_all("clear", 1'b0);
    endtask

    initial begin
        int k;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start_b = 1'b0;
        clear_b = 1'b0;
        ksel    = 3'd0;
        junk    = 3'd0;
        thr     = 8'h00;
        smp     = 16'h0000;
        model_clear();
        m_n = 1;

        repeat (3) @(negedge clk);
        check_all("reset", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // k=0 single sample, threshold 0
        do_sample(16'h1234, 3'd0);

        // k=2, mean of 1,2,3,6 = 3
        do_sample(16'h0001, 3'd2);
        do_sample(16'h0002, 3'd2);
        do_sample(16'h0003, 3'd2);
        do_sample(16'h0006, 3'd2);
        check_eq("k2_mean", 32'({res_msb, res_lsb}), 32'h0003);

        // k=7 full-scale, threshold 0xFF00
        thr = 8'hFF;
        for (int i = 0; i < 128; i++) do_sample(16'hFFFF, 3'd7);
        check_eq("k7_ffff", 32'({res_msb, res_lsb}), 32'hFFFF);
        for (int i = 0; i < 128; i++) do_sample(16'hFEFF, 3'd7);
        check_eq("k7_feff_above", 32'(asic_lsb[2]), 32'd0);

        // Two START edges 2 cycles apart: second is dropped
        @(negedge clk);
        begin
            int mid;
            smp = 16'h0100; ksel = 3'd2; start_b = 1'b1;
            model_sample(16'h0100, 3'd2, mid);
        end
        @(negedge clk); start_b = 1'b0;
        @(negedge clk); start_b = 1'b1; smp = 16'h0777;
        @(negedge clk); start_b = 1'b0;
        m_dropped = 1;
        @(negedge clk);
        check_all("dropped", 1'b0);
        do_clear();

        // k=3: two samples, then CLEAR together with a START edge
        thr = 8'h10;
        do_sample(16'h0400, 3'd3);
        do_sample(16'h0800, 3'd3);
        @(negedge clk);
        clear_b = 1'b1; start_b = 1'b1; smp = 16'hABCD;
        @(negedge clk);
        model_clear();
        check_all("clr_start", 1'b0);
        clear_b = 1'b0;
        @(negedge clk);
        check_all("clr_nostart", 1'b0);
        start_b = 1'b0;
        // 8-sample sequence; later samples carry a different AVG_SEL
        for (int i = 0; i < 8; i++)
            do_sample(16'($urandom), (i == 0) ? 3'd3 : 3'($urandom_range(0, 7)));
        check_eq("k3_done", 32'(asic_lsb[1]), 32'd1);

        // Asynchronous reset in the middle of ACCUM
        @(negedge clk);
        smp = 16'h5555; ksel = 3'd1; start_b = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check_all("async_rst", 1'b0);
        @(negedge clk); start_b = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        do_sample(16'h1000, 3'd1);
        do_sample(16'h3001, 3'd1);
        check_eq("post_rst_mean", 32'({res_msb, res_lsb}), 32'h2000);

        // Randomized sequences
        for (int seq = 0; seq < 8; seq++) begin
            k   = $urandom_range(0, 4);
            thr = 8'($urandom);
            for (int i = 0; i < (1 << k); i++)
                do_sample(16'($urandom), (i == 0) ? 3'(k) : 3'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
